// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES key-expansion controller blocks.
// Provides the mode/state enums and the per-mode round-constant count and last value.
package aes_ctrl_pkg;

    typedef enum logic [1:0] {
        AES128 = 2'b00,
        AES192 = 2'b01,
        AES256 = 2'b10
    } aes_mode_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } rcon_state_e;

    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] AES_POLY  = 8'h1B;

    // The unused encoding 2'b11 falls back to AES-128.
    function automatic aes_mode_e decode_mode(input logic [1:0] raw);
        case (raw)
            2'b01:   return AES192;
            2'b10:   return AES256;
            default: return AES128;
        endcase
    endfunction

    function automatic logic [3:0] num_rcon(input aes_mode_e mode);
        case (mode)
            AES192:  return 4'd8;
            AES256:  return 4'd7;
            default: return 4'd10;
        endcase
    endfunction

    function automatic logic [7:0] rcon_last(input aes_mode_e mode);
        case (mode)
            AES192:  return 8'h80;
            AES256:  return 8'h40;
            default: return 8'h36;
        endcase
    endfunction

endpackage

// File: rtl/gf8_mul2_div2.sv
// One GF(2^8) round-constant step: multiply by x (forward) or divide by x (inv).
// The inverse path exists only when AES_RCON_INV_EN is defined.
module gf8_mul2_div2
    import aes_ctrl_pkg::*;
(
    input  logic [7:0] in,
    input  logic       inv,
    output logic [7:0] out
);

    logic [7:0] mul2;

    assign mul2 = {in[6:0], 1'b0} ^ (in[7] ? AES_POLY : 8'h00);

`ifdef AES_RCON_INV_EN
    logic [7:0] div2;

    // An odd value had the reduction polynomial folded in; undo it and restore bit 7.
    assign div2 = in[0] ? (((in ^ AES_POLY) >> 1) | 8'h80) : (in >> 1);
    assign out  = inv ? div2 : mul2;
`else
    logic unused_inv;

    assign unused_inv = inv;
    assign out        = mul2;
`endif

endmodule

// File: rtl/aes_rcon_seq.sv
// AES round-constant sequencer: steps rcon once every STEP_CYCLES enabled cycles
// for AES-128/192/256. Reverse stepping is compiled in with AES_RCON_INV_EN.
module aes_rcon_seq
    import aes_ctrl_pkg::*;
#(
    parameter int STEP_CYCLES = 20,
    parameter int CNT_W       = $clog2(STEP_CYCLES + 1)
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [1:0] mode,
    input  logic       dir,
    input  logic       step_en,
    output logic [7:0] rcon,
    output logic [3:0] rcon_idx,
    output logic       rcon_valid,
    output logic       round_tick,
    output logic       busy,
    output logic       done
);

    rcon_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        rcon_q, rcon_d;
    logic [3:0]        idx_q, idx_d;
    aes_mode_e         mode_q, mode_d;
    logic              dir_q, dir_d;

    logic              dir_eff;
    logic [7:0]        rcon_step;
    logic              last_cnt;
    logic              last_step;
    aes_mode_e         mode_in;

`ifdef AES_RCON_INV_EN
    assign dir_eff = dir;
`else
    logic unused_dir;

    assign unused_dir = dir;
    assign dir_eff    = 1'b0;
`endif

    gf8_mul2_div2 u_step (
        .in  (rcon_q),
        .inv (dir_q),
        .out (rcon_step)
    );

    assign mode_in   = decode_mode(mode);
    assign last_cnt  = (cnt_q == CNT_W'(STEP_CYCLES - 1));
    assign last_step = dir_q ? (idx_q == 4'd0) : (idx_q == num_rcon(mode_q) - 4'd1);

    // NOTE: every variable gets its hold value first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rcon_d     = rcon_q;
        idx_d      = idx_q;
        mode_d     = mode_q;
        dir_d      = dir_q;
        round_tick = 1'b0;

        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
            rcon_d  = RCON_INIT;
            idx_d   = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = RUN;
                        mode_d  = mode_in;
                        dir_d   = dir_eff;
                        cnt_d   = '0;
                        if (dir_eff) begin
                            rcon_d = rcon_last(mode_in);
                            idx_d  = num_rcon(mode_in) - 4'd1;
                        end else begin
                            rcon_d = RCON_INIT;
                            idx_d  = 4'd0;
                        end
                    end
                end
                RUN: begin
                    if (step_en) begin
                        if (last_cnt) begin
                            round_tick = 1'b1;
                            cnt_d      = '0;
                            if (last_step) begin
                                state_d = DONE;
                            end else begin
                                rcon_d = rcon_step;
                                idx_d  = dir_q ? idx_q - 4'd1 : idx_q + 4'd1;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    rcon_d  = RCON_INIT;
                    idx_d   = 4'd0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rcon_q  <= RCON_INIT;
            idx_q   <= 4'd0;
            mode_q  <= AES128;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rcon_q  <= rcon_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
        end
    end

    assign rcon       = rcon_q;
    assign rcon_idx   = idx_q;
    assign rcon_valid = (state_q == RUN);
    assign busy       = (state_q == RUN) || (state_q == DONE);
    assign done       = (state_q == DONE);

endmodule

// File: tb/tb_aes_rcon_seq.sv
// Self-checking bench for aes_rcon_seq: table-driven full sequences, randomized
// stalls/ignored inputs against a sequence model, and hand-written corner cases.
module tb_aes_rcon_seq;

    localparam int SC = 20;

    logic       clk;
    logic       rst;
    logic       start;
    logic       start1;
    logic       abort;
    logic [1:0] mode;
    logic       dir;
    logic       step_en;

    logic [7:0] rcon, rcon1;
    logic [3:0] rcon_idx, rcon_idx1;
    logic       rcon_valid, rcon_valid1;
    logic       round_tick, round_tick1;
    logic       busy, busy1;
    logic       done, done1;

    int total = 0;
    int bad   = 0;

    // Round constants x^i in GF(2^8), i = 0..9.
    logic [7:0] fwd_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

    aes_rcon_seq #(.STEP_CYCLES(SC)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode), .dir(dir),
        .step_en(step_en), .rcon(rcon), .rcon_idx(rcon_idx), .rcon_valid(rcon_valid),
        .round_tick(round_tick), .busy(busy), .done(done)
    );

    aes_rcon_seq #(.STEP_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort), .mode(mode), .dir(dir),
        .step_en(step_en), .rcon(rcon1), .rcon_idx(rcon_idx1), .rcon_valid(rcon_valid1),
        .round_tick(round_tick1), .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int model_n(input logic [1:0] m);
        if (m == 2'b01) return 8;
        if (m == 2'b10) return 7;
        return 10;
    endfunction

    function automatic logic model_rev(input logic d);
`ifdef AES_RCON_INV_EN
        return d;
`else
        return 1'b0 & d;
`endif
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Full sequence against the model; with rnd set, stalls and junk start/mode/dir are injected.
    task automatic run_seq(input logic [1:0] m, input logic d, input bit rnd,
                           output logic [7:0] first_r, output logic [7:0] last_r,
                           output int ticks);
        int n, e, cyc, k;
        logic rev;
        n       = model_n(m);
        rev     = model_rev(d);
        ticks   = 0;
        first_r = 8'h00;
        last_r  = 8'h00;
        next_cycle();
        mode = m; dir = d; start = 1'b1; step_en = 1'b1;
        next_cycle();
        start = 1'b0;
        e = 0;
        cyc = 0;
        while (e < n * SC && cyc < 3000) begin
            if (rnd) begin
                step_en = ($urandom_range(0, 3) != 0);
                start   = 1'($urandom);
                mode    = 2'($urandom);
                dir     = 1'($urandom);
            end
            @(negedge clk);
            k = rev ? (n - 1 - e / SC) : (e / SC);
            check("run_rcon", rcon, fwd_tab[k]);
            check("run_idx", rcon_idx, k);
            check("run_valid", rcon_valid, 1);
            check("run_busy", busy, 1);
            check("run_done", done, 0);
            check("run_tick", round_tick, (step_en && (e % SC == SC - 1)) ? 1 : 0);
            if (cyc == 0) first_r = rcon;
            last_r = rcon;
            if (round_tick) ticks++;
            if (step_en) e++;
            cyc++;
            next_cycle();
        end
        check("run_budget", (e == n * SC) ? 1 : 0, 1);
        start = 1'b0;
        step_en = 1'b1;
        @(negedge clk);
        check("done_pulse", done, 1);
        check("done_busy", busy, 1);
        check("done_valid", rcon_valid, 0);
        check("done_rcon_hold", rcon, fwd_tab[rev ? 0 : n - 1]);
        check("done_idx_hold", rcon_idx, rev ? 0 : n - 1);
        next_cycle();
        @(negedge clk);
        check("post_done", done, 0);
        check("post_busy", busy, 0);
        check("post_rcon", rcon, 8'h01);
        check("post_idx", rcon_idx, 0);
    endtask

    typedef struct {
        logic [1:0] mode;
        logic       dir;
        int         n;
        logic [7:0] first;
        logic [7:0] last;
    } vec_t;

    initial begin
        vec_t vecs [6];
        logic [7:0] f, l;
        int   t;
        int   c;
        bit   seen;

        vecs[0] = '{2'b00, 1'b0, 10, 8'h01, 8'h36};
        vecs[1] = '{2'b01, 1'b0, 8,  8'h01, 8'h80};
        vecs[2] = '{2'b10, 1'b0, 7,  8'h01, 8'h40};
        vecs[3] = '{2'b11, 1'b0, 10, 8'h01, 8'h36};
`ifdef AES_RCON_INV_EN
        vecs[4] = '{2'b00, 1'b1, 10, 8'h36, 8'h01};
        vecs[5] = '{2'b10, 1'b1, 7,  8'h40, 8'h01};
`else
        vecs[4] = '{2'b00, 1'b1, 10, 8'h01, 8'h36};
        vecs[5] = '{2'b10, 1'b1, 7,  8'h01, 8'h40};
`endif

        rst = 1'b0; start = 1'b0; start1 = 1'b0; abort = 1'b0;
        mode = 2'b00; dir = 1'b0; step_en = 1'b1;
        repeat (3) next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check("rst_rcon", rcon, 8'h01);
        check("rst_idx", rcon_idx, 0);
        check("rst_valid", rcon_valid, 0);
        check("rst_tick", round_tick, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);

        for (int i = 0; i < 6; i++) begin
            run_seq(vecs[i].mode, vecs[i].dir, 1'b0, f, l, t);
            check("vec_ticks", t, vecs[i].n);
            check("vec_first", f, vecs[i].first);
            check("vec_last", l, vecs[i].last);
        end

        for (int i = 0; i < 8; i++) begin
            run_seq(2'($urandom), 1'($urandom), 1'b1, f, l, t);
        end

        // Seven stall cycles inside the first step push its tick from cycle 19 to 26.
        next_cycle();
        mode = 2'b00; dir = 1'b0; start = 1'b1; step_en = 1'b1;
        next_cycle();
        start = 1'b0;
        seen = 1'b0;
        for (c = 0; c < 100; c++) begin
            step_en = !(c >= 5 && c < 12);
            @(negedge clk);
            if (round_tick) begin
                seen = 1'b1;
                break;
            end
            next_cycle();
        end
        check("stall_tick_seen", seen, 1);
        check("stall_tick_cycle", c, 26);
        next_cycle();
        step_en = 1'b1;

        // Abort once index 4 is showing.
        seen = 1'b0;
        for (int j = 0; j < 200; j++) begin
            @(negedge clk);
            if (rcon_idx == 4'd4) begin
                seen = 1'b1;
                break;
            end
            next_cycle();
        end
        check("abort_idx4_seen", seen, 1);
        check("abort_idx4_rcon", rcon, 8'h10);
        abort = 1'b1;
        next_cycle();
        abort = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_valid", rcon_valid, 0);
        check("abort_rcon", rcon, 8'h01);
        check("abort_idx", rcon_idx, 0);
        check("abort_done", done, 0);
        for (int j = 0; j < 3; j++) begin
            next_cycle();
            @(negedge clk);
            check("abort_no_done", done, 0);
        end

        next_cycle();
        abort = 1'b1; start = 1'b1;
        next_cycle();
        abort = 1'b0; start = 1'b0;
        @(negedge clk);
        check("abort_start_busy", busy, 0);
        check("abort_start_valid", rcon_valid, 0);
        next_cycle();
        @(negedge clk);
        check("abort_start_busy2", busy, 0);

        // STEP_CYCLES=1: a tick and a new constant on every enabled cycle.
        next_cycle();
        mode = 2'b00; dir = 1'b0; step_en = 1'b1; start1 = 1'b1;
        next_cycle();
        start1 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("sc1_tick", round_tick1, 1);
            check("sc1_rcon", rcon1, fwd_tab[k]);
            next_cycle();
        end
        @(negedge clk);
        check("sc1_done", done1, 1);
        check("sc1_tick_off", round_tick1, 0);

        // Asynchronous reset in the middle of a run takes effect without a clock edge.
        next_cycle();
        mode = 2'b00; dir = 1'b0; start = 1'b1;
        next_cycle();
        start = 1'b0;
        repeat (30) next_cycle();
        @(negedge clk);
        check("pre_rst_rcon", rcon, 8'h02);
        #2;
        rst = 1'b0;
        #1;
        check("arst_rcon", rcon, 8'h01);
        check("arst_idx", rcon_idx, 0);
        check("arst_busy", busy, 0);
        check("arst_valid", rcon_valid, 0);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check("arst_stay_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
